// File: rtl/csc_pkg.sv
// Shared types and coefficient tables for the RGB->YCbCr converter.
// Coefficients are scaled by 2^COEF_FRAC; rows are Y/Cb/Cr, columns R/G/B.
package csc_pkg;

    localparam int COEF_FRAC = 8;
    localparam int LAT       = 3;

    typedef logic signed [8:0] coef_t;

    typedef struct packed {
        coef_t r;
        coef_t g;
        coef_t b;
    } coef_row_t;

    typedef enum logic {
        MODE_601 = 1'b0,
        MODE_709 = 1'b1
    } csc_mode_e;

    localparam logic [1:0] ROW_Y  = 2'd0;
    localparam logic [1:0] ROW_CB = 2'd1;
    localparam logic [1:0] ROW_CR = 2'd2;

    localparam coef_row_t COEF_601 [0:2] = '{
        '{9'sd77,   9'sd150,  9'sd29},
        '{-9'sd43,  -9'sd85,  9'sd128},
        '{9'sd128,  -9'sd107, -9'sd21}
    };

    localparam coef_row_t COEF_709 [0:2] = '{
        '{9'sd54,   9'sd183,  9'sd19},
        '{-9'sd29,  -9'sd99,  9'sd128},
        '{9'sd128,  -9'sd116, -9'sd12}
    };

    function automatic coef_row_t coef_sel(input csc_mode_e mode, input logic [1:0] row);
        coef_row_t res;
        case (mode)
            MODE_709: res = COEF_709[row];
            default:  res = COEF_601[row];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rgb2ycbcr_csc_if.sv
// Video bus of the converter: RGB input side and YCbCr output side.
interface rgb2ycbcr_csc_if #(
    parameter int DW = 8
);
    logic            in_hsync;
    logic            in_vsync;
    logic            in_de;
    logic [3*DW-1:0] in_data;
    logic            out_hsync;
    logic            out_vsync;
    logic            out_de;
    logic [DW-1:0]   out_y;
    logic [DW-1:0]   out_cb;
    logic [DW-1:0]   out_cr;

    modport slave (
        input  in_hsync, in_vsync, in_de, in_data,
        output out_hsync, out_vsync, out_de, out_y, out_cb, out_cr
    );

    modport master (
        output in_hsync, in_vsync, in_de, in_data,
        input  out_hsync, out_vsync, out_de, out_y, out_cb, out_cr
    );
endinterface

// File: rtl/csc_row.sv
// One output component: 3-tap signed MAC with rounding and optional chroma offset.
// Two register stages; the clamped result is left combinational for the caller to register.
module csc_row
    import csc_pkg::*;
#(
    parameter int DW     = 8,
    parameter int FRAC   = 8,
    parameter bit CHROMA = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  coef_row_t       coef_i,
    input  logic [3*DW-1:0] pix_i,
    output logic [DW-1:0]   sat_o
);

    localparam int PW = DW + FRAC + 1;
    localparam int AW = DW + FRAC + 2;

    localparam logic signed [AW-1:0] RND  = AW'(32'd1 << (FRAC - 1));
    localparam logic signed [AW-1:0] OFFS = CHROMA ? AW'(32'd1 << (DW - 1 + FRAC)) : {AW{1'b0}};

    logic signed [PW-1:0] prod_r_d, prod_g_d, prod_b_d;
    logic signed [PW-1:0] prod_r_q, prod_g_q, prod_b_q;
    logic signed [AW-1:0] acc_d, acc_q;

    // Arithmetic shift drops the fraction; the sign bit and the bits above DW decide the clamp.
    function automatic logic [DW-1:0] clamp(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        logic [DW-1:0]        res;
        s = a >>> FRAC;
        if (s[AW-1]) begin
            res = {DW{1'b0}};
        end else if (|s[AW-2:DW]) begin
            res = {DW{1'b1}};
        end else begin
            res = s[DW-1:0];
        end
        return res;
    endfunction

    // Stage-1 products and stage-2 sum; pixels are unsigned, widened with a zero sign bit.
    always_comb begin
        prod_r_d = PW'(coef_i.r) * PW'($signed({1'b0, pix_i[3*DW-1:2*DW]}));
        prod_g_d = PW'(coef_i.g) * PW'($signed({1'b0, pix_i[2*DW-1:DW]}));
        prod_b_d = PW'(coef_i.b) * PW'($signed({1'b0, pix_i[DW-1:0]}));
        acc_d    = AW'(prod_r_q) + AW'(prod_g_q) + AW'(prod_b_q) + RND + OFFS;
    end

    // Product and accumulator pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r_q <= {PW{1'b0}};
            prod_g_q <= {PW{1'b0}};
            prod_b_q <= {PW{1'b0}};
            acc_q    <= {AW{1'b0}};
        end else begin
            prod_r_q <= prod_r_d;
            prod_g_q <= prod_g_d;
            prod_b_q <= prod_b_d;
            acc_q    <= acc_d;
        end
    end

    assign sat_o = clamp(acc_q);

endmodule

// File: rtl/rgb2ycbcr_csc.sv
// RGB->YCbCr converter, BT.601/BT.709 latched at frame start, fixed 3-cycle latency.
// Define CSC_422_EN for 4:2:2 co-sited output (Cb/Cr interleaved on out_cb, out_cr held at 0).
module rgb2ycbcr_csc
    import csc_pkg::*;
#(
    parameter int DW   = 8,
    parameter int FRAC = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode_i,
    rgb2ycbcr_csc_if.slave vid
);

    logic           active_mode_q, active_mode_d;
    logic           vsync_d_q;
    logic [LAT-1:0] hs_q, vs_q, de_q;
    coef_row_t      coef_y_s, coef_cb_s, coef_cr_s;
    logic [DW-1:0]  y_s, cb_s, cr_s;
    logic [DW-1:0]  y_q, cb_q, cr_q;
    logic [DW-1:0]  cb_d, cr_d;

    // Mode only changes on a rising vsync, so a frame never mixes coefficient sets.
    always_comb begin
        active_mode_d = active_mode_q;
        if (vid.in_vsync && !vsync_d_q) begin
            active_mode_d = mode_i;
        end else begin
            active_mode_d = active_mode_q;
        end
    end

    assign coef_y_s  = coef_sel(csc_mode_e'(active_mode_q), ROW_Y);
    assign coef_cb_s = coef_sel(csc_mode_e'(active_mode_q), ROW_CB);
    assign coef_cr_s = coef_sel(csc_mode_e'(active_mode_q), ROW_CR);

    csc_row #(.DW(DW), .FRAC(FRAC), .CHROMA(1'b0)) u_row_y (
        .clk(clk), .rst_n(rst_n), .coef_i(coef_y_s), .pix_i(vid.in_data), .sat_o(y_s)
    );
    csc_row #(.DW(DW), .FRAC(FRAC), .CHROMA(1'b1)) u_row_cb (
        .clk(clk), .rst_n(rst_n), .coef_i(coef_cb_s), .pix_i(vid.in_data), .sat_o(cb_s)
    );
    csc_row #(.DW(DW), .FRAC(FRAC), .CHROMA(1'b1)) u_row_cr (
        .clk(clk), .rst_n(rst_n), .coef_i(coef_cr_s), .pix_i(vid.in_data), .sat_o(cr_s)
    );

`ifdef CSC_422_EN
    logic          phase_q, phase_d;
    logic [DW-1:0] held_cr_q, held_cr_d;

    // de_q[LAT-2] travels with the pixel entering the output register.
    always_comb begin
        phase_d   = 1'b0;
        held_cr_d = held_cr_q;
        cb_d      = cb_s;
        cr_d      = {DW{1'b0}};
        if (de_q[LAT-2]) begin
            if (!phase_q) begin
                held_cr_d = cr_s;
                phase_d   = 1'b1;
            end else begin
                cb_d    = held_cr_q;
                phase_d = 1'b0;
            end
        end else begin
            phase_d = 1'b0;
        end
    end

    // Chroma phase and held Cr registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= 1'b0;
            held_cr_q <= {DW{1'b0}};
        end else begin
            phase_q   <= phase_d;
            held_cr_q <= held_cr_d;
        end
    end
`else
    // Full 4:4:4 output.
    always_comb begin
        cb_d = cb_s;
        cr_d = cr_s;
    end
`endif

    // Mode latch, sync/de delay line and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_mode_q <= 1'b0;
            vsync_d_q     <= 1'b0;
            hs_q          <= {LAT{1'b0}};
            vs_q          <= {LAT{1'b0}};
            de_q          <= {LAT{1'b0}};
            y_q           <= {DW{1'b0}};
            cb_q          <= {DW{1'b0}};
            cr_q          <= {DW{1'b0}};
        end else begin
            active_mode_q <= active_mode_d;
            vsync_d_q     <= vid.in_vsync;
            hs_q          <= {hs_q[LAT-2:0], vid.in_hsync};
            vs_q          <= {vs_q[LAT-2:0], vid.in_vsync};
            de_q          <= {de_q[LAT-2:0], vid.in_de};
            y_q           <= y_s;
            cb_q          <= cb_d;
            cr_q          <= cr_d;
        end
    end

    assign vid.out_hsync = hs_q[LAT-1];
    assign vid.out_vsync = vs_q[LAT-1];
    assign vid.out_de    = de_q[LAT-1];
    assign vid.out_y     = y_q;
    assign vid.out_cb    = cb_q;
    assign vid.out_cr    = cr_q;

endmodule
